// File: rtl/otter_pkg.sv
// Types and constants shared across the OTTER RV32I pipeline stages.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_IMM  = 2'd2,
        OP1_ZERO = 2'd3
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2,
        OP2_ZERO = 2'd3
    } op2_sel_t;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic valid, input logic [4:0] rd, input logic [4:0] addr);
        return valid && (addr != 5'd0) && (rd == addr);
    endfunction

endpackage

// File: rtl/ex_fwd_mux.sv
// Per-operand RAW forwarding select: the youngest producer (MEM) wins over WB.
module ex_fwd_mux #(
    parameter int XLEN = otter_pkg::XLEN
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] reg_data,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_data
);
    import otter_pkg::*;

    always_comb begin
        fwd_data = reg_data;
        if (fwd_hit(mem_fwd_valid, mem_rd_addr, rs_addr)) begin
            fwd_data = mem_result;
        end else if (fwd_hit(wb_fwd_valid, wb_rd_addr, rs_addr)) begin
            fwd_data = wb_result;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with execute-stage forwarding and ALU operand selection.
module ex_operand_stage #(
    parameter int XLEN      = otter_pkg::XLEN,
    parameter int WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_fun,
    input  logic [1:0]      id_op1_sel,
    input  logic [1:0]      id_op2_sel,
    input  logic            mem_fwd_valid,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_fwd_valid,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic [3:0]      ex_alu_fun,
    output logic [XLEN-1:0] alu_op_1,
    output logic [XLEN-1:0] alu_op_2,
    output logic [XLEN-1:0] ex_store_data
);
    import otter_pkg::*;

    logic [4:0]      ex_rs1_addr;
    logic [4:0]      ex_rs2_addr;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    op1_sel_t        ex_op1_sel;
    op2_sel_t        ex_op2_sel;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] id_rs1_capt;
    logic [XLEN-1:0] id_rs2_capt;

    ex_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr       (ex_rs1_addr),
        .reg_data      (ex_rs1_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs1)
    );

    ex_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr       (ex_rs2_addr),
        .reg_data      (ex_rs2_data),
        .mem_fwd_valid (mem_fwd_valid),
        .mem_rd_addr   (mem_rd_addr),
        .mem_result    (mem_result),
        .wb_fwd_valid  (wb_fwd_valid),
        .wb_rd_addr    (wb_rd_addr),
        .wb_result     (wb_result),
        .fwd_data      (fwd_rs2)
    );

    // The regfile read in ID misses a same-cycle WB write, so capture wb_result instead.
    always_comb begin
        id_rs1_capt = id_rs1_data;
        id_rs2_capt = id_rs2_data;
        if (WB_BYPASS != 0) begin
            if (fwd_hit(wb_fwd_valid, wb_rd_addr, id_rs1_addr)) id_rs1_capt = wb_result;
            if (fwd_hit(wb_fwd_valid, wb_rd_addr, id_rs2_addr)) id_rs2_capt = wb_result;
        end
    end

    // During a stall the operand data keeps refreshing so a producer leaving WB is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rd_addr  <= '0;
            ex_alu_fun  <= ALU_ADD;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_op1_sel  <= OP1_RS1;
            ex_op2_sel  <= OP2_RS2;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_rd_addr <= '0;
        end else if (stall) begin
            ex_rs1_data <= fwd_rs1;
            ex_rs2_data <= fwd_rs2;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rd_addr  <= id_valid ? id_rd_addr : 5'd0;
            ex_alu_fun  <= id_alu_fun;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            ex_rs1_data <= id_rs1_capt;
            ex_rs2_data <= id_rs2_capt;
            ex_imm      <= id_imm;
            ex_op1_sel  <= op1_sel_t'(id_op1_sel);
            ex_op2_sel  <= op2_sel_t'(id_op2_sel);
        end
    end

    always_comb begin
        alu_op_1 = '0;
        alu_op_2 = '0;
        case (ex_op1_sel)
            OP1_RS1:  alu_op_1 = fwd_rs1;
            OP1_PC:   alu_op_1 = ex_pc;
            OP1_IMM:  alu_op_1 = ex_imm;
            OP1_ZERO: alu_op_1 = '0;
            default:  alu_op_1 = '0;
        endcase
        case (ex_op2_sel)
            OP2_RS2:  alu_op_2 = fwd_rs2;
            OP2_IMM:  alu_op_2 = ex_imm;
            OP2_FOUR: alu_op_2 = XLEN'(4);
            OP2_ZERO: alu_op_2 = '0;
            default:  alu_op_2 = '0;
        endcase
    end

    assign ex_store_data = fwd_rs2;

endmodule
